rf_wb_arb: RTL and testbench



---
 rtl/rf_wb_arb.sv | 129 ++++++++++++
 tb/tb_rf_wb_arb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arb.sv
// Register file writeback arbiter: merges ALU results and returning loads onto a
// single write port, with a 2-entry load return buffer and a pending-load scoreboard.
module rf_wb_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_we,
    input  logic [3:0]  alu_addr,
    input  logic [15:0] alu_data,
    input  logic        ld_iss,
    input  logic [3:0]  ld_iss_addr,
    input  logic        ld_vld,
    input  logic [3:0]  ld_addr,
    input  logic [15:0] ld_data,
    output logic        ld_rdy,
    output logic        we,
    output logic [3:0]  dst_addr,
    output logic [15:0] dst,
    output logic [15:0] pend,
    output logic        ovf
);

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned NREG  = 16;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 2;

    logic [AW-1:0]   r_buf_addr [DEPTH];
    logic [DW-1:0]   r_buf_data [DEPTH];
    logic            r_rd_ptr;
    logic            r_wr_ptr;
    logic [CW-1:0]   r_cnt;
    logic            r_ld_rdy;
    logic            r_we;
    logic [AW-1:0]   r_dst_addr;
    logic [DW-1:0]   r_dst;
    logic [NREG-1:0] r_pend;
    logic            r_ovf;

    logic            w_alu_win;
    logic            w_pop;
    logic            w_direct;
    logic            w_push;
    logic            w_drop;
    logic            w_ld_emit;
    logic [AW-1:0]   w_ld_addr;
    logic [DW-1:0]   w_ld_data;
    logic            w_wr_en;
    logic [AW-1:0]   w_wr_addr;
    logic [DW-1:0]   w_wr_data;
    logic [NREG-1:0] w_pend_nxt;
    logic [CW-1:0]   w_cnt_nxt;

    // Port arbitration: ALU first, then buffer head, then a bypassing load
    always_comb begin
        w_alu_win  = alu_we && (alu_addr != '0);
        w_pop      = !w_alu_win && (r_cnt != '0);
        w_direct   = !w_alu_win && (r_cnt == '0) && ld_vld;
        w_push     = ld_vld && !w_direct && r_ld_rdy;
        w_drop     = ld_vld && !w_direct && !r_ld_rdy;
        w_ld_emit  = w_pop || w_direct;
        w_ld_addr  = w_pop ? r_buf_addr[r_rd_ptr] : ld_addr;
        w_ld_data  = w_pop ? r_buf_data[r_rd_ptr] : ld_data;
        w_wr_en    = w_alu_win || (w_ld_emit && (w_ld_addr != '0));
        w_wr_addr  = w_alu_win ? alu_addr : w_ld_addr;
        w_wr_data  = w_alu_win ? alu_data : w_ld_data;
        w_pend_nxt = r_pend;
        if (w_ld_emit) begin
            w_pend_nxt = w_pend_nxt & ~(NREG'(1) << w_ld_addr);
        end
        // Issue applied after clear so a same-cycle set wins
        if (ld_iss && (ld_iss_addr != '0)) begin
            w_pend_nxt = w_pend_nxt | (NREG'(1) << ld_iss_addr);
        end
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end else if (w_pop && !w_push) begin
            w_cnt_nxt = r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_buf_addr[i] <= '0;
                r_buf_data[i] <= '0;
            end
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_cnt      <= '0;
            r_ld_rdy   <= 1'b1;
            r_we       <= 1'b0;
            r_dst_addr <= '0;
            r_dst      <= '0;
            r_pend     <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_push) begin
                r_buf_addr[r_wr_ptr] <= ld_addr;
                r_buf_data[r_wr_ptr] <= ld_data;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_cnt    <= w_cnt_nxt;
            r_ld_rdy <= (w_cnt_nxt < CW'(DEPTH));
            r_we     <= w_wr_en;
            // Address and data hold their last values while the port is idle
            if (w_wr_en) begin
                r_dst_addr <= w_wr_addr;
                r_dst      <= w_wr_data;
            end
            r_pend <= w_pend_nxt;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign ld_rdy   = r_ld_rdy;
    assign we       = r_we;
    assign dst_addr = r_dst_addr;
    assign dst      = r_dst;
    assign pend     = r_pend;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_rf_wb_arb.sv
// Self-checking bench for rf_wb_arb: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_rf_wb_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_we;
    logic [3:0]  alu_addr;
    logic [15:0] alu_data;
    logic        ld_iss;
    logic [3:0]  ld_iss_addr;
    logic        ld_vld;
    logic [3:0]  ld_addr;
    logic [15:0] ld_data;
    logic        ld_rdy;
    logic        we;
    logic [3:0]  dst_addr;
    logic [15:0] dst;
    logic [15:0] pend;
    logic        ovf;

    int n_chk = 0;
    int n_err = 0;

    rf_wb_arb dut (
        .clk(clk), .rst_n(rst_n),
        .alu_we(alu_we), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_iss(ld_iss), .ld_iss_addr(ld_iss_addr),
        .ld_vld(ld_vld), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_rdy(ld_rdy), .we(we), .dst_addr(dst_addr), .dst(dst),
        .pend(pend), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        aw;  logic [3:0] aa;  logic [15:0] ad;
        logic        li;  logic [3:0] lia;
        logic        lv;  logic [3:0] la;  logic [15:0] ld;
        logic        ewe; logic [3:0] ea;  logic [15:0] ed;
        logic        erdy; logic [15:0] ep; logic eovf;
    } vec_t;

    typedef struct { logic [3:0] a; logic [15:0] d; } ent_t;

    // Reference model: an ordered queue of returned loads plus architectural outputs
    ent_t        m_q[$];
    logic [15:0] m_pend;
    logic        m_ovf;
    logic        m_we;
    logic [3:0]  m_addr;
    logic [15:0] m_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend = '0; m_ovf = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0;
    endtask

    task automatic model_emit_load(input logic [3:0] a, input logic [15:0] d);
        if (a != 4'd0) begin
            m_we = 1'b1; m_addr = a; m_data = d;
        end
        m_pend[a] = 1'b0;
    endtask

    task automatic model_step();
        bit   used;
        bit   room;
        ent_t h;
        ent_t n;
        used = 1'b0;
        room = (m_q.size() < 2);
        m_we = 1'b0;
        if (alu_we && alu_addr != 4'd0) begin
            m_we = 1'b1; m_addr = alu_addr; m_data = alu_data;
        end else if (m_q.size() > 0) begin
            h = m_q.pop_front();
            model_emit_load(h.a, h.d);
        end else if (ld_vld) begin
            model_emit_load(ld_addr, ld_data);
            used = 1'b1;
        end
        if (ld_vld && !used) begin
            if (room) begin
                n.a = ld_addr; n.d = ld_data;
                m_q.push_back(n);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (ld_iss && ld_iss_addr != 4'd0) m_pend[ld_iss_addr] = 1'b1;
    endtask

    task automatic drive(input logic aw, input logic [3:0] aa, input logic [15:0] ad,
                         input logic li, input logic [3:0] lia,
                         input logic lv, input logic [3:0] la, input logic [15:0] ld);
        alu_we = aw; alu_addr = aa; alu_data = ad;
        ld_iss = li; ld_iss_addr = lia;
        ld_vld = lv; ld_addr = la; ld_data = ld;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_we"},   32'(we),       32'(m_we));
        chk({tag, "_addr"}, 32'(dst_addr), 32'(m_addr));
        chk({tag, "_dst"},  32'(dst),      32'(m_data));
        chk({tag, "_pend"}, 32'(pend),     32'(m_pend));
        chk({tag, "_ovf"},  32'(ovf),      32'(m_ovf));
        chk({tag, "_rdy"},  32'(ld_rdy),   32'(m_q.size() < 2));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_we"},   32'(we),       32'(0));
        chk({tag, "_addr"}, 32'(dst_addr), 32'(0));
        chk({tag, "_dst"},  32'(dst),      32'(0));
        chk({tag, "_pend"}, 32'(pend),     32'(0));
        chk({tag, "_rdy"},  32'(ld_rdy),   32'(1));
        chk({tag, "_ovf"},  32'(ovf),      32'(0));
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 16'h1234, 1'b1, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd3, 16'h1234, 1'b1, 16'h0020, 1'b0};
        tbl[2]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd5, 16'hBEEF, 1'b1, 4'd5, 16'hBEEF, 1'b1, 16'h0000, 1'b0};
        tbl[3]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd5, 16'hBEEF, 1'b1, 16'h0000, 1'b0};
        tbl[4]  = '{1'b1, 4'd2, 16'h0002, 1'b0, 4'd0, 1'b1, 4'd4, 16'hAAAA, 1'b1, 4'd2, 16'h0002, 1'b1, 16'h0000, 1'b0};
        tbl[5]  = '{1'b1, 4'd6, 16'h0006, 1'b0, 4'd0, 1'b1, 4'd7, 16'hBBBB, 1'b1, 4'd6, 16'h0006, 1'b0, 16'h0000, 1'b0};
        tbl[6]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd4, 16'hAAAA, 1'b1, 16'h0000, 1'b0};
        tbl[7]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 16'hBBBB, 1'b1, 16'h0000, 1'b0};
        tbl[8]  = '{1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd7, 16'hBBBB, 1'b1, 16'h0000, 1'b0};
        tbl[9]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd0, 16'h1111, 1'b0, 4'd7, 16'hBBBB, 1'b1, 16'h0000, 1'b0};
        tbl[10] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd1, 1'b1, 4'd1, 16'hCCCC, 1'b1, 4'd1, 16'hCCCC, 1'b1, 16'h0002, 1'b0};
        tbl[11] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd1, 16'hCCCC, 1'b1, 16'h0002, 1'b0};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors: basic write, load round trip, ordering, R0, set-wins
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].aw, tbl[i].aa, tbl[i].ad, tbl[i].li, tbl[i].lia,
                  tbl[i].lv, tbl[i].la, tbl[i].ld);
            cycle();
            chk($sformatf("tbl%0d_we", i),   32'(we),       32'(tbl[i].ewe));
            chk($sformatf("tbl%0d_addr", i), 32'(dst_addr), 32'(tbl[i].ea));
            chk($sformatf("tbl%0d_dst", i),  32'(dst),      32'(tbl[i].ed));
            chk($sformatf("tbl%0d_rdy", i),  32'(ld_rdy),   32'(tbl[i].erdy));
            chk($sformatf("tbl%0d_pend", i), 32'(pend),     32'(tbl[i].ep));
            chk($sformatf("tbl%0d_ovf", i),  32'(ovf),      32'(tbl[i].eovf));
        end

        // Overflow: ALU holds the port while three loads return
        drive(1, 8, 16'h0008, 0, 0, 1, 9, 16'h0009);
        cycle();
        chk("ovf_a_rdy", 32'(ld_rdy), 32'(1));
        drive(1, 8, 16'h0008, 0, 0, 1, 10, 16'h000A);
        cycle();
        chk("ovf_b_rdy", 32'(ld_rdy), 32'(0));
        chk("ovf_b_ovf", 32'(ovf), 32'(0));
        drive(1, 8, 16'h0008, 0, 0, 1, 11, 16'h000B);
        cycle();
        chk("ovf_c_ovf", 32'(ovf), 32'(1));
        chk("ovf_c_rdy", 32'(ld_rdy), 32'(0));
        drive(1, 8, 16'h0008, 0, 0, 0, 0, 0);
        cycle();
        chk("ovf_d_ovf", 32'(ovf), 32'(1));
        chk("ovf_d_we",  32'(we), 32'(1));

        // Asynchronous reset with a full buffer, away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("arst");
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("post_rst_we0",  32'(we), 32'(0));
        chk("post_rst_rdy",  32'(ld_rdy), 32'(1));
        cycle();
        chk("post_rst_we1",  32'(we), 32'(0));
        chk("post_rst_ovf",  32'(ovf), 32'(0));

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 9) < 4), 4'($urandom_range(0, 15)), 16'($urandom),
                  ($urandom_range(0, 9) < 3), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) < 5), 4'($urandom_range(0, 15)), 16'($urandom));
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                chk_model("rnd_rst");
                @(posedge clk);
                #2;
                rst_n = 1'b1;
            end else begin
                cycle();
                chk_model("rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
